// File: rtl/spi_pkg.sv
// Shared types, defaults and helpers for the system-clock-domain SPI slave.
package spi_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   localparam int unsigned SPI_DATA_W_DEF = 8;
   localparam int unsigned SPI_SYNC_DEF   = 2;

   // The sample edge is the rising sclk edge exactly when CPOL equals CPHA.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/spi_slave_sync_pin_sync.sv
// Synchronises the asynchronous SPI pins into clk and produces one-cycle edge pulses.
// Level outputs are delayed one extra flop so they line up with the registered pulses.
module spi_pin_sync
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SPI_SYNC_DEF,
   parameter logic        SCLK_IDLE   = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sclk,
   input  logic i_cs_n,
   input  logic i_mosi,
   output logic o_cs_n_q,
   output logic o_mosi_q,
   output logic o_sclk_rise,
   output logic o_sclk_fall,
   output logic o_cs_fall,
   output logic o_cs_rise
);

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_q;
   logic                   r_cs_n_q;
   logic                   r_mosi_q;
   logic                   r_sclk_rise;
   logic                   r_sclk_fall;
   logic                   r_cs_fall;
   logic                   r_cs_rise;
   logic                   w_sclk_s;
   logic                   w_cs_n_s;
   logic                   w_mosi_s;

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n_s = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   // Synchroniser chains, reset to the idle pin levels so reset release creates no false edges.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      end
   end

   // Registered edge pulses plus aligned levels.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sclk_q    <= SCLK_IDLE;
         r_cs_n_q    <= 1'b1;
         r_mosi_q    <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_sclk_fall <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_cs_rise   <= 1'b0;
      end else begin
         r_sclk_q    <= w_sclk_s;
         r_cs_n_q    <= w_cs_n_s;
         r_mosi_q    <= w_mosi_s;
         r_sclk_rise <= w_sclk_s & ~r_sclk_q;
         r_sclk_fall <= ~w_sclk_s & r_sclk_q;
         r_cs_fall   <= ~w_cs_n_s & r_cs_n_q;
         r_cs_rise   <= w_cs_n_s & ~r_cs_n_q;
      end
   end

   assign o_cs_n_q    = r_cs_n_q;
   assign o_mosi_q    = r_mosi_q;
   assign o_sclk_rise = r_sclk_rise;
   assign o_sclk_fall = r_sclk_fall;
   assign o_cs_fall   = r_cs_fall;
   assign o_cs_rise   = r_cs_rise;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the clk domain: all four modes, DATA_W-bit words,
// multi-word frames, valid/ready rx and tx interfaces.
// Optional macro SPI_SLAVE_OVERRUN_EN adds a sticky rx_overrun flag.
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = SPI_DATA_W_DEF,
   parameter int unsigned CPOL        = 0,
   parameter int unsigned CPHA        = 0,
   parameter int unsigned MSB_FIRST   = 1,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe
`ifdef SPI_SLAVE_OVERRUN_EN
   ,
   output logic              rx_overrun
`endif
);

   localparam int unsigned CNT_W       = $clog2(DATA_W);
   localparam logic        SAMPLE_RISE = sample_on_rise(1'(CPOL), 1'(CPHA));
   localparam logic        CPHA1       = (CPHA != 0);
   localparam logic        MSB         = (MSB_FIRST != 0);

   spi_state_e        r_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_rx_shift;
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_empty;
   logic              r_miso;
   logic              r_miso_oe;

   logic              w_cs_n_q;
   logic              w_mosi_q;
   logic              w_sclk_rise;
   logic              w_sclk_fall;
   logic              w_cs_fall;
   logic              w_cs_rise;
   logic              w_sample;
   logic              w_shift;
   logic              w_last_bit;
   logic              w_start;
   logic              w_active;
   logic              w_word_done;
   logic              w_load;
   logic              w_tx_wr;
   logic [DATA_W-1:0] w_rx_next;
   logic [DATA_W-1:0] w_load_word;
   logic [DATA_W-1:0] w_load_shifted;
   logic              w_load_first;
   logic [DATA_W-1:0] w_tx_shifted;
   logic              w_tx_first;

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .SCLK_IDLE   (1'(CPOL))
   ) u_pin_sync (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sclk      (sclk),
      .i_cs_n      (cs_n),
      .i_mosi      (mosi),
      .o_cs_n_q    (w_cs_n_q),
      .o_mosi_q    (w_mosi_q),
      .o_sclk_rise (w_sclk_rise),
      .o_sclk_fall (w_sclk_fall),
      .o_cs_fall   (w_cs_fall),
      .o_cs_rise   (w_cs_rise)
   );

   assign w_sample       = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
   assign w_shift        = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
   assign w_last_bit     = (r_bit_cnt == CNT_W'(DATA_W-1));
   assign w_start        = (r_state == ST_IDLE) && w_cs_fall;
   assign w_active       = (r_state == ST_ACTIVE) && !w_cs_rise;
   assign w_word_done    = w_active && w_sample && w_last_bit;
   assign w_load         = w_start || w_word_done;
   assign w_tx_wr        = tx_valid && r_hold_empty;

   assign w_rx_next      = MSB ? {r_rx_shift[DATA_W-2:0], w_mosi_q}
                               : {w_mosi_q, r_rx_shift[DATA_W-1:1]};
   assign w_load_word    = r_hold_empty ? '0 : r_hold;
   assign w_load_first   = MSB ? w_load_word[DATA_W-1] : w_load_word[0];
   assign w_load_shifted = MSB ? {w_load_word[DATA_W-2:0], 1'b0}
                               : {1'b0, w_load_word[DATA_W-1:1]};
   assign w_tx_first     = MSB ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
   assign w_tx_shifted   = MSB ? {r_tx_shift[DATA_W-2:0], 1'b0}
                               : {1'b0, r_tx_shift[DATA_W-1:1]};

   // Frame FSM with rx/tx shifters, bit counter, rx output register and MISO drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_rx_shift <= '0;
         r_tx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_miso     <= 1'b0;
         r_miso_oe  <= 1'b0;
      end else begin
         r_miso_oe <= ~w_cs_n_q;

         if (w_word_done) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state    <= ST_ACTIVE;
                  r_bit_cnt  <= '0;
                  r_rx_shift <= '0;
                  if (CPHA1) begin
                     r_tx_shift <= w_load_word;
                     r_miso     <= 1'b0;
                  end else begin
                     r_tx_shift <= w_load_shifted;
                     r_miso     <= w_load_first;
                  end
               end
            end
            ST_ACTIVE: begin
               if (w_cs_rise) begin
                  r_state    <= ST_IDLE;
                  r_bit_cnt  <= '0;
                  r_rx_shift <= '0;
                  r_tx_shift <= '0;
                  r_miso     <= 1'b0;
               end else if (w_sample) begin
                  r_rx_shift <= w_rx_next;
                  if (w_last_bit) begin
                     r_bit_cnt  <= '0;
                     r_tx_shift <= w_load_word;
                  end else begin
                     r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                  end
               end else if (w_shift) begin
                  r_miso     <= w_tx_first;
                  r_tx_shift <= w_tx_shifted;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Tx holding register: a write wins over the empty-on-load, so a same-cycle write refills it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold       <= '0;
         r_hold_empty <= 1'b1;
      end else if (w_tx_wr) begin
         r_hold       <= tx_data;
         r_hold_empty <= 1'b0;
      end else if (w_load) begin
         r_hold_empty <= 1'b1;
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic r_overrun;

   // Sticky flag for a completed word that overwrote an unconsumed one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_word_done && r_rx_valid && !rx_ready) begin
         r_overrun <= 1'b1;
      end
   end

   assign rx_overrun = r_overrun;
`endif

   assign tx_ready = r_hold_empty;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign miso     = r_miso;
   assign miso_oe  = r_miso_oe;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four instances (modes 0..3, mixed bit order) driven by one
// bit-level SPI master, table-driven frames plus hand-written abort/overrun/reset sequences.
module tb_spi_slave_sync;

   localparam int NI = 4;
   localparam int H  = 4;                        // sclk half period in clk cycles (clk = 8x sclk)
   localparam logic [NI-1:0] P_CPOL = 4'b1100;
   localparam logic [NI-1:0] P_CPHA = 4'b1010;
   localparam logic [NI-1:0] P_MSB  = 4'b0101;  // instances 1 and 3 are LSB-first

   logic            clk = 1'b0;
   logic            rst;
   logic            cs_n;
   logic [NI-1:0]   sclk;
   logic [NI-1:0]   mosi;
   logic [NI-1:0]   miso;
   logic [NI-1:0]   miso_oe;
   logic [NI-1:0]   tx_valid = '0;
   logic [NI-1:0]   tx_ready;
   logic [NI-1:0]   rx_valid;
   logic [NI-1:0]   rx_ready;
   logic [7:0]      tx_data [NI] = '{default: 8'h00};
   logic [7:0]      rx_data [NI];
`ifdef SPI_SLAVE_OVERRUN_EN
   logic [NI-1:0]   rx_overrun;
`endif

   logic [7:0]      tx_q [NI][$];
   logic [7:0]      rx_q [NI][$];
   logic [7:0]      m_tx [3];
   logic [7:0]      m_rx [NI][3];

   int              n_checks = 0;
   int              n_err    = 0;

   typedef struct {
      int               n;
      logic [2:0][7:0]  mtx;
      int               ntx;
      logic [1:0][7:0]  stx;
      logic [2:0][7:0]  exp_rx;
      logic [2:0][7:0]  exp_miso;
   } vec_t;

   vec_t vec [5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      spi_slave_sync #(
         .DATA_W      (8),
         .CPOL        (32'(P_CPOL[g])),
         .CPHA        (32'(P_CPHA[g])),
         .MSB_FIRST   (32'(P_MSB[g])),
         .SYNC_STAGES (2)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .tx_data  (tx_data[g]),
         .tx_valid (tx_valid[g]),
         .tx_ready (tx_ready[g]),
         .rx_data  (rx_data[g]),
         .rx_valid (rx_valid[g]),
         .rx_ready (rx_ready[g]),
         .sclk     (sclk[g]),
         .cs_n     (cs_n),
         .mosi     (mosi[g]),
         .miso     (miso[g]),
         .miso_oe  (miso_oe[g])
`ifdef SPI_SLAVE_OVERRUN_EN
         ,
         .rx_overrun (rx_overrun[g])
`endif
      );
   end

   // Handshake monitor: record accepted rx words, retire accepted tx words.
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst && rx_valid[k] && rx_ready[k]) rx_q[k].push_back(rx_data[k]);
         if (!rst && tx_valid[k] && tx_ready[k]) void'(tx_q[k].pop_front());
      end
   end

   // Tx feeder: present the head of each tx queue.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (tx_q[k].size() > 0) begin
            tx_valid[k] = 1'b1;
            tx_data[k]  = tx_q[k][0];
         end else begin
            tx_valid[k] = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   task automatic half();
      repeat (H) @(negedge clk);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bit-level master for all instances at once; last word may be truncated to nbits_last bits.
   task automatic spi_xfer(input int nwords, input int nbits_last, input bit keep_cs);
      int idx;
      int nb;
      for (int k = 0; k < NI; k++)
         for (int w = 0; w < 3; w++) m_rx[k][w] = 8'h00;
      cs_n = 1'b0;
      half();
      half();
      for (int w = 0; w < nwords; w++) begin
         nb = (w == nwords - 1) ? nbits_last : 8;
         for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < NI; k++) begin
               idx = P_MSB[k] ? 7 - i : i;
               if (!P_CPHA[k]) mosi[k] = m_tx[w][idx];
            end
            half();
            for (int k = 0; k < NI; k++) begin
               idx = P_MSB[k] ? 7 - i : i;
               if (!P_CPHA[k]) m_rx[k][w][idx] = miso[k];
               else            mosi[k] = m_tx[w][idx];
               sclk[k] = ~P_CPOL[k];
            end
            half();
            for (int k = 0; k < NI; k++) begin
               idx = P_MSB[k] ? 7 - i : i;
               if (P_CPHA[k]) m_rx[k][w][idx] = miso[k];
               sclk[k] = P_CPOL[k];
            end
         end
      end
      half();
      if (!keep_cs) begin
         cs_n = 1'b1;
         half();
         half();
      end
   endtask

   task automatic clear_rx();
      for (int k = 0; k < NI; k++) rx_q[k].delete();
   endtask

   function automatic logic [7:0] rx_word(input int k, input int w);
      logic [7:0] v;
      v = 8'hxx;
      if (w < rx_q[k].size()) v = rx_q[k][w];
      return v;
   endfunction

   function automatic vec_t mk(input int n, input logic [7:0] m0, m1, m2,
                               input int ntx, input logic [7:0] t0, t1,
                               input logic [7:0] e0, e1, e2);
      vec_t v;
      v.n        = n;
      v.mtx      = {m2, m1, m0};
      v.ntx      = ntx;
      v.stx      = {t1, t0};
      v.exp_rx   = {m2, m1, m0};
      v.exp_miso = {e2, e1, e0};
      return v;
   endfunction

   initial begin
      vec[0] = mk(1, 8'hA5, 8'h00, 8'h00, 1, 8'h3C, 8'h00, 8'h3C, 8'h00, 8'h00);
      vec[1] = mk(1, 8'h96, 8'h00, 8'h00, 1, 8'h96, 8'h00, 8'h96, 8'h00, 8'h00);
      vec[2] = mk(3, 8'hC1, 8'hC2, 8'hC3, 2, 8'h11, 8'h22, 8'h11, 8'h22, 8'h00);
      vec[3] = mk(2, 8'h0F, 8'hF0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      vec[4] = mk(1, 8'h01, 8'h00, 8'h00, 1, 8'h80, 8'h00, 8'h80, 8'h00, 8'h00);

      rst      = 1'b1;
      cs_n     = 1'b1;
      sclk     = P_CPOL;
      mosi     = '0;
      rx_ready = '1;
      wait_clk(3);

      for (int k = 0; k < NI; k++) begin
         chk("reset_tx_ready", k, 32'(tx_ready[k]), 32'd1);
         chk("reset_rx_valid", k, 32'(rx_valid[k]), 32'd0);
         chk("reset_rx_data",  k, 32'(rx_data[k]),  32'd0);
         chk("reset_miso",     k, 32'(miso[k]),     32'd0);
         chk("reset_miso_oe",  k, 32'(miso_oe[k]),  32'd0);
      end
      rst = 1'b0;
      wait_clk(4);

      // Table-driven frames.
      for (int v = 0; v < 5; v++) begin
         clear_rx();
         for (int k = 0; k < NI; k++)
            for (int t = 0; t < vec[v].ntx; t++) tx_q[k].push_back(vec[v].stx[t]);
         wait_clk(4);
         for (int w = 0; w < 3; w++) m_tx[w] = vec[v].mtx[w];
         spi_xfer(vec[v].n, 8, 1'b0);
         wait_clk(20);
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("v%0d_rx_count", v), k, 32'(rx_q[k].size()), 32'(vec[v].n));
            for (int w = 0; w < vec[v].n; w++) begin
               chk($sformatf("v%0d_rx_w%0d", v, w),   k, 32'(rx_word(k, w)), 32'(vec[v].exp_rx[w]));
               chk($sformatf("v%0d_miso_w%0d", v, w), k, 32'(m_rx[k][w]),    32'(vec[v].exp_miso[w]));
            end
         end
      end

      // cs_n rises after 5 bits: partial word dropped, next frame clean.
      clear_rx();
      m_tx[0] = 8'hFF;
      spi_xfer(1, 5, 1'b0);
      wait_clk(20);
      for (int k = 0; k < NI; k++) begin
         chk("abort_rx_count", k, 32'(rx_q[k].size()), 32'd0);
         chk("abort_rx_valid", k, 32'(rx_valid[k]),    32'd0);
      end
      m_tx[0] = 8'h5A;
      spi_xfer(1, 8, 1'b0);
      wait_clk(20);
      for (int k = 0; k < NI; k++) begin
         chk("after_abort_count", k, 32'(rx_q[k].size()), 32'd1);
         chk("after_abort_rx",    k, 32'(rx_word(k, 0)),  32'h5A);
         chk("after_abort_miso",  k, 32'(m_rx[k][0]),     32'h00);
      end

      // Consumer stalled across two words: newest wins.
      clear_rx();
      rx_ready = '0;
      m_tx[0]  = 8'h01;
      m_tx[1]  = 8'h02;
      spi_xfer(2, 8, 1'b0);
      wait_clk(20);
      for (int k = 0; k < NI; k++) begin
         chk("stall_rx_valid", k, 32'(rx_valid[k]), 32'd1);
         chk("stall_rx_data",  k, 32'(rx_data[k]),  32'h02);
`ifdef SPI_SLAVE_OVERRUN_EN
         chk("stall_overrun",  k, 32'(rx_overrun[k]), 32'd1);
`endif
      end
      rx_ready = '1;
      wait_clk(3);
      for (int k = 0; k < NI; k++) begin
         chk("drain_rx_valid", k, 32'(rx_valid[k]),    32'd0);
         chk("drain_count",    k, 32'(rx_q[k].size()), 32'd1);
         chk("drain_word",     k, 32'(rx_word(k, 0)),  32'h02);
`ifdef SPI_SLAVE_OVERRUN_EN
         chk("overrun_sticky", k, 32'(rx_overrun[k]), 32'd1);
`endif
      end

      // Reset in the middle of a word with cs_n held low.
      clear_rx();
      for (int k = 0; k < NI; k++) tx_q[k].push_back(8'h77);
      wait_clk(4);
      for (int k = 0; k < NI; k++) chk("pre_rst_tx_ready", k, 32'(tx_ready[k]), 32'd0);
      m_tx[0] = 8'hEE;
      spi_xfer(1, 4, 1'b1);
      for (int k = 0; k < NI; k++) chk("mid_frame_miso_oe", k, 32'(miso_oe[k]), 32'd1);
      rst = 1'b1;
      wait_clk(2);
      for (int k = 0; k < NI; k++) begin
         chk("rst_tx_ready", k, 32'(tx_ready[k]), 32'd1);
         chk("rst_rx_valid", k, 32'(rx_valid[k]), 32'd0);
         chk("rst_rx_data",  k, 32'(rx_data[k]),  32'd0);
         chk("rst_miso",     k, 32'(miso[k]),     32'd0);
         chk("rst_miso_oe",  k, 32'(miso_oe[k]),  32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
         chk("rst_overrun",  k, 32'(rx_overrun[k]), 32'd0);
`endif
      end
      rst = 1'b0;
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(3 * H);
      clear_rx();
      m_tx[0] = 8'hC3;
      spi_xfer(1, 8, 1'b0);
      wait_clk(20);
      for (int k = 0; k < NI; k++) begin
         chk("post_rst_count", k, 32'(rx_q[k].size()), 32'd1);
         chk("post_rst_rx",    k, 32'(rx_word(k, 0)),  32'hC3);
         chk("post_rst_miso",  k, 32'(m_rx[k][0]),     32'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
